vdp_super_palette: RTL

//  256-entry 24-bit RGB palette for the super-res/super-mid pixel path. Receives the
//  8-bit palette index stream (PALETTE_ADDR2) from the super-res pixel fetcher.

---
 rtl/vdp_super_palette.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vdp_super_palette.sv
// rtl/vdp_super_palette.sv - 256x24 super-res palette with CPU 3-byte port and default fill
module vdp_super_palette #(
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_index,
  output logic [7:0] pixel_red,
  output logic [7:0] pixel_green,
  output logic [7:0] pixel_blue,
  input  logic       cpu_index_wr,
  input  logic       cpu_data_wr,
  input  logic       cpu_data_rd,
  input  logic [7:0] cpu_data,
  output logic [7:0] cpu_rd_data,
  output logic       init_busy
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_fill;
  logic [7:0]  r_ptr;
  logic [1:0]  r_phase;
  logic [7:0]  r_stage_r;
  logic [7:0]  r_stage_g;
  logic [23:0] r_ram [256];
  logic [23:0] r_pix;
  logic [7:0]  r_cpu_rd;

  logic        w_cpu_en;
  logic        w_ram_we;
  logic [7:0]  w_ram_addr;
  logic [23:0] w_ram_wdata;
  logic [23:0] w_cpu_word;
  logic [7:0]  w_cpu_comp;

  // Port B is shared: the fill counter owns it in INIT, the CPU pointer afterwards.
  always_comb begin
    w_state_next = r_state;
    w_cpu_en     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_ptr;
    w_ram_wdata  = {r_stage_r, r_stage_g, cpu_data};
    case (r_state)
      S_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_fill;
        w_ram_wdata = {r_fill[7:5], r_fill[7:5], r_fill[7:6],
                       r_fill[4:2], r_fill[4:2], r_fill[4:3],
                       {4{r_fill[1:0]}}};
        if (r_fill == 8'hFF) w_state_next = S_IDLE;
      end
      default: begin
        w_cpu_en = 1'b1;
        w_ram_we = !cpu_index_wr && cpu_data_wr && (r_phase == PH_B);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT_ON_RESET ? S_INIT : S_IDLE;
      r_fill  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT) r_fill <= r_fill + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= 8'd0;
      r_phase   <= PH_R;
      r_stage_r <= 8'd0;
      r_stage_g <= 8'd0;
    end else if (w_cpu_en) begin
      if (cpu_index_wr) begin
        r_ptr   <= cpu_data;
        r_phase <= PH_R;
      end else if (cpu_data_wr || cpu_data_rd) begin
        if (cpu_data_wr && r_phase == PH_R) r_stage_r <= cpu_data;
        if (cpu_data_wr && r_phase == PH_G) r_stage_g <= cpu_data;
        if (r_phase == PH_B) begin
          r_ptr   <= r_ptr + 8'd1;
          r_phase <= PH_R;
        end else begin
          r_phase <= r_phase + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
  end

  assign w_cpu_word = r_ram[w_ram_addr];

  always_comb begin
    w_cpu_comp = w_cpu_word[7:0];
    case (r_phase)
      PH_R:    w_cpu_comp = w_cpu_word[23:16];
      PH_G:    w_cpu_comp = w_cpu_word[15:8];
      default: w_cpu_comp = w_cpu_word[7:0];
    endcase
  end

  // Both read registers sample the pre-write RAM word, giving read-first behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix    <= 24'd0;
      r_cpu_rd <= 8'd0;
    end else begin
      r_pix    <= r_ram[pixel_index];
      r_cpu_rd <= w_cpu_comp;
    end
  end

  assign pixel_red   = r_pix[23:16];
  assign pixel_green = r_pix[15:8];
  assign pixel_blue  = r_pix[7:0];
  assign cpu_rd_data = r_cpu_rd;
  assign init_busy   = (r_state == S_INIT);

endmodule
